// File: rtl/mux8_pkg.sv
// Shared widths and named select codes for the 8-to-1 single-bit mux.
package mux8_pkg;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned N_IN  = 8;

    localparam int unsigned SEL_I0 = 0;
    localparam int unsigned SEL_I1 = 1;
    localparam int unsigned SEL_I2 = 2;
    localparam int unsigned SEL_I3 = 3;
    localparam int unsigned SEL_I4 = 4;
    localparam int unsigned SEL_I5 = 5;
    localparam int unsigned SEL_I6 = 6;
    localparam int unsigned SEL_I7 = 7;

endpackage

// File: rtl/decoder_3x8_gates.sv
// Gate-level 3-to-8 minterm decoder: one AND of true/inverted select bits per line.
module decoder_3x8_gates
    import mux8_pkg::*;
(
    input  logic            s2,
    input  logic            s1,
    input  logic            s0,
    output logic [N_IN-1:0] minterm
);

    logic ns2;
    logic ns1;
    logic ns0;

    // Select inverters; X/Z on a select bit propagates through these untouched.
    assign ns2 = ~s2;
    assign ns1 = ~s1;
    assign ns0 = ~s0;

    assign minterm[SEL_I0] = ns2 & ns1 & ns0;
    assign minterm[SEL_I1] = ns2 & ns1 & s0;
    assign minterm[SEL_I2] = ns2 & s1  & ns0;
    assign minterm[SEL_I3] = ns2 & s1  & s0;
    assign minterm[SEL_I4] = s2  & ns1 & ns0;
    assign minterm[SEL_I5] = s2  & ns1 & s0;
    assign minterm[SEL_I6] = s2  & s1  & ns0;
    assign minterm[SEL_I7] = s2  & s1  & s0;

endmodule

// File: rtl/mux_8x1_sel.sv
// Gate-level 8:1 single-bit mux with registered copy Y_q.
// Optional registered one-hot select decode dec_q when MUX8_DECODE_OUT_EN is defined.
module mux_8x1_sel
    import mux8_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            I0,
    input  logic            I1,
    input  logic            I2,
    input  logic            I3,
    input  logic            I4,
    input  logic            I5,
    input  logic            I6,
    input  logic            I7,
    input  logic            S0,
    input  logic            S1,
    input  logic            S2,
    input  logic            en,
`ifdef MUX8_DECODE_OUT_EN
    output logic [N_IN-1:0] dec_q,
`endif
    output logic            Y,
    output logic            Y_q
);

    logic [N_IN-1:0] minterm;
    logic [N_IN-1:0] y_term;

    decoder_3x8_gates u_dec (
        .s2      (S2),
        .s1      (S1),
        .s0      (S0),
        .minterm (minterm)
    );

    // Each data input gated by its select minterm (4-input AND overall).
    assign y_term[SEL_I0] = minterm[SEL_I0] & I0;
    assign y_term[SEL_I1] = minterm[SEL_I1] & I1;
    assign y_term[SEL_I2] = minterm[SEL_I2] & I2;
    assign y_term[SEL_I3] = minterm[SEL_I3] & I3;
    assign y_term[SEL_I4] = minterm[SEL_I4] & I4;
    assign y_term[SEL_I5] = minterm[SEL_I5] & I5;
    assign y_term[SEL_I6] = minterm[SEL_I6] & I6;
    assign y_term[SEL_I7] = minterm[SEL_I7] & I7;

    // 8-input OR; Y is independent of clk, rst_n and en.
    assign Y = y_term[SEL_I0] | y_term[SEL_I1] | y_term[SEL_I2] | y_term[SEL_I3]
             | y_term[SEL_I4] | y_term[SEL_I5] | y_term[SEL_I6] | y_term[SEL_I7];

    // Enable-gated capture of the combinational result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y_q <= 1'b0;
        end else if (en) begin
            Y_q <= Y;
        end
    end

`ifdef MUX8_DECODE_OUT_EN
    // Decode register tracks the select every cycle, regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= '0;
        end else begin
            dec_q <= minterm;
        end
    end
`endif

endmodule

// File: tb/tb_mux_8x1_sel.sv
// Scoreboard bench for mux_8x1_sel: driver queues expectations, monitor checks on each sample strobe.
module tb_mux_8x1_sel;

    localparam int unsigned K_Y   = 0;
    localparam int unsigned K_YQ  = 1;
    localparam int unsigned K_DEC = 2;

    typedef struct {
        int unsigned kind;
        logic [7:0]  exp;
        string       tag;
    } sb_item_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_vec;
    logic [2:0] sel;
    logic       en;
    logic       y;
    logic       y_q;
`ifdef MUX8_DECODE_OUT_EN
    logic [7:0] dec_q;
`endif

    sb_item_t sb[$];
    event     sample_ev;
    int       checks;
    int       errors;

    mux_8x1_sel dut (
        .clk   (clk),
        .rst_n (rst_n),
        .I0    (i_vec[0]),
        .I1    (i_vec[1]),
        .I2    (i_vec[2]),
        .I3    (i_vec[3]),
        .I4    (i_vec[4]),
        .I5    (i_vec[5]),
        .I6    (i_vec[6]),
        .I7    (i_vec[7]),
        .S0    (sel[0]),
        .S1    (sel[1]),
        .S2    (sel[2]),
        .en    (en),
`ifdef MUX8_DECODE_OUT_EN
        .dec_q (dec_q),
`endif
        .Y     (y),
        .Y_q   (y_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input int unsigned kind, input logic [7:0] exp, input string tag);
        sb_item_t it;
        it.kind = kind;
        it.exp  = exp;
        it.tag  = tag;
        sb.push_back(it);
        -> sample_ev;
        #1;
    endtask

    // Monitor: pops one expectation per sample strobe and compares.
    initial begin
        sb_item_t   it;
        logic [7:0] act;
        checks = 0;
        errors = 0;
        forever begin
            @(sample_ev);
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow actual=empty required=entry");
            end else begin
                it  = sb.pop_front();
                act = 8'h00;
                case (it.kind)
                    K_Y:  act = {7'b0, y};
                    K_YQ: act = {7'b0, y_q};
`ifdef MUX8_DECODE_OUT_EN
                    K_DEC: act = dec_q;
`endif
                    default: act = 8'hxx;
                endcase
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s actual=%h required=%h", it.tag, act, it.exp);
                end
            end
        end
    end

    initial begin
        logic [10:0] combo;
        logic [7:0]  ones;
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 3'd0;
        i_vec = 8'h00;

        // Reset state
        #2;
        expect_val(K_YQ, 8'h00, "reset_yq");
`ifdef MUX8_DECODE_OUT_EN
        expect_val(K_DEC, 8'h00, "reset_dec");
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Walking one: only the selected input high
        for (int s = 0; s < 8; s++) begin
            sel   = 3'(s);
            ones  = 8'h01;
            i_vec = ones << s;
            #5;
            expect_val(K_Y, 8'h01, $sformatf("walk1_sel%0d", s));
            #4;
        end

        // Walking zero: only the selected input low
        for (int s = 0; s < 8; s++) begin
            sel   = 3'(s);
            ones  = 8'h01;
            i_vec = ~(ones << s);
            #5;
            expect_val(K_Y, 8'h00, $sformatf("walk0_sel%0d", s));
            #4;
        end

        // Registered path with enable
        @(negedge clk);
        en    = 1'b1;
        sel   = 3'b110;
        i_vec = 8'b0100_0000;
        #1;
        expect_val(K_Y, 8'h01, "reg_y_before");
        @(posedge clk);
        #1;
        expect_val(K_YQ, 8'h01, "reg_yq_capture");
        en    = 1'b0;
        i_vec = 8'h00;
        #1;
        expect_val(K_Y, 8'h00, "reg_y_after_drop");
        expect_val(K_YQ, 8'h01, "reg_yq_hold");
        @(posedge clk);
        #1;
        expect_val(K_YQ, 8'h01, "reg_yq_hold_edge");
`ifdef MUX8_DECODE_OUT_EN
        expect_val(K_DEC, 8'h40, "dec_sel6_en0");
`endif

        // Async reset between edges; Y keeps following inputs
        #1;
        rst_n = 1'b0;
        #1;
        expect_val(K_YQ, 8'h00, "async_reset_yq");
`ifdef MUX8_DECODE_OUT_EN
        expect_val(K_DEC, 8'h00, "async_reset_dec");
`endif
        i_vec = 8'b0100_0000;
        #1;
        expect_val(K_Y, 8'h01, "reset_y_follows");
        @(posedge clk);
        #1;
        expect_val(K_YQ, 8'h00, "reset_yq_held");

        // First capture after release
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        sel   = 3'b011;
        i_vec = 8'b0000_1000;
        @(posedge clk);
        #1;
        expect_val(K_YQ, 8'h01, "post_reset_capture");
`ifdef MUX8_DECODE_OUT_EN
        expect_val(K_DEC, 8'h08, "dec_sel3");
`endif
        i_vec = 8'hF7;
        @(posedge clk);
        #1;
        expect_val(K_YQ, 8'h00, "capture_zero");
        en = 1'b0;

        // Exhaustive: all 2^11 data/select combinations
        for (int n = 0; n < 2048; n++) begin
            combo = 11'(n);
            i_vec = combo[7:0];
            sel   = combo[10:8];
            #1;
            expect_val(K_Y, {7'b0, combo[32'(combo[10:8])]}, $sformatf("exh_%0h", n));
        end

        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_8x1_sel.md
# mux_8x1_sel

Gate-level 8-to-1 single-bit multiplexer with a registered output copy, used wherever a datapath has to pick one of eight 1-bit sources under a 3-bit select. The select is decoded through explicit AND/OR/NOT gate logic into a combinational output Y. A clocked stage captures Y into Y_q for synchronous consumers. An optional one-hot decode output exposes the active select line.

## Interface
Parameters:
- none (fixed 8 inputs, 1-bit data)

Ports:
- clk  input  1  sole clock; all registers on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- I0..I7  input  1 each  data inputs; I0 selected by code 0, I7 by code 7
- S0  input  1  select LSB
- S1  input  1  select middle bit
- S2  input  1  select MSB
- en  input  1  capture enable for Y_q
- Y  output  1  combinational mux output
- Y_q  output  1  registered copy of Y
- dec_q  output  8  registered one-hot select decode (only with MUX8_DECODE_OUT_EN)

## Operation
- sel = {S2,S1,S0}; Y = I[sel], e.g. sel=3'b101 gives Y=I5.
- Y is built from gates only: inverters on S0..S2, eight 4-input ANDs (one select minterm plus Ix), and one 8-input OR. No behavioural case statement or ternary.
- Y is purely combinational. It does not depend on clk, rst_n or en.
- Y_q: on rising clk with en=1, Y_q <= Y. With en=0, Y_q holds its value.
- dec_q[k] <= (sel==k) on every rising clk, independent of en. Exactly one bit is set after the first edge following reset.
- X/Z on a select bit propagates per gate semantics. No sanitising.

## Timing
- Y: zero-cycle latency, valid one gate-delay path after any input change.
- Y_q: 1-cycle latency from Y, gated by en.
- Reset: rst_n=0 forces Y_q=0 and dec_q=8'h00 immediately, without waiting for clk. Y keeps following its inputs during reset.
- Reset deassertion: first capture happens on the first rising clk with rst_n=1.
- Simultaneous select change and clk edge: Y_q takes the Y value settled before the edge (standard setup rules).

## Configuration
- Macro: MUX8_DECODE_OUT_EN.
- Defined: the dec_q[7:0] port and its register exist, with behaviour as in Operation.
- Undefined: no dec_q port and no decode register. Y and Y_q are unchanged.

## Structure
- Shared package mux8_pkg:
  - SEL_W = 3
  - N_IN = 8
  - Named select codes SEL_I0..SEL_I7 = 0..7
- Sub-module decoder_3x8_gates takes S2..S0 and produces 8 minterm lines using gates only.
  - Top level ANDs each minterm with its Ix and ORs the results.
  - The same minterms feed dec_q.

## Test plan
- Walking one: for each sel 0..7, drive I[sel]=1 and all others 0, hold 10 ns -> Y=1. Sequence 000,001,…,111 gives Y=1 in every case.
- Walking zero: I[sel]=0 and all others 1 for each sel -> Y=0, proving no leakage from unselected inputs.
- Registered path: rst_n=1, en=1, sel=3'b110, I6=1 -> Y_q=1 one clk after. Then set en=0 and I6=0 -> Y=0 while Y_q stays 1.
- Async reset: with Y_q=1, pull rst_n=0 between clock edges -> Y_q=0 immediately. Y still follows the inputs.
- Decode (MUX8_DECODE_OUT_EN): sel=3'b011 -> dec_q=8'h08 after the next edge. Reset -> dec_q=8'h00.
- Exhaustive: all 2^11 input combinations -> Y matches the reference I[sel] every time.
